// File: rtl/bouttons_poller_pkg.sv
// Shared definitions for the button PIO poller: poll FSM states and PIO register map.
package bouttons_poller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        UPDATE
    } poll_state_t;

    localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;

endpackage

// File: rtl/bouttons_avalon_poller_debounce_bit.sv
// Per-button debouncer: a changed sample must persist for DEBOUNCE_POLLS strobes
// before the clean state flips, with a one-cycle press/release pulse on the flip.
module debounce_bit #(
    parameter int DEBOUNCE_POLLS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    input  logic sample_strobe,
    output logic state,
    output logic press,
    output logic released
);

    localparam int unsigned CW = $clog2(DEBOUNCE_POLLS + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
            cnt      <= '0;
        end else begin
            press    <= 1'b0;
            released <= 1'b0;
            if (sample_strobe) begin
                if (sample != state) begin
                    // Reaching the threshold flips immediately, so the counter never wraps.
                    if (cnt == CW'(DEBOUNCE_POLLS - 1)) begin
                        state    <= ~state;
                        cnt      <= '0;
                        press    <= ~state;
                        released <= state;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/bouttons_avalon_poller.sv
// Avalon-MM read master that periodically polls the button PIO and debounces
// each bit, exposing clean state plus press/release pulses.
module bouttons_avalon_poller
    import bouttons_poller_pkg::*;
#(
    parameter int WIDTH          = 2,
    parameter int POLL_PERIOD    = 50000,
    parameter int DEBOUNCE_POLLS = 4,
    parameter int READ_LATENCY   = 1,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic             avm_waitrequest,
    input  logic [31:0]      avm_readdata,
    output logic [WIDTH-1:0] btn_state,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic             sample_valid
);

    localparam int unsigned TW = (POLL_PERIOD  > 1) ? $clog2(POLL_PERIOD)  : 1;
    localparam int unsigned LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    poll_state_t      state, state_next;
    logic [TW-1:0]    timer;
    logic [LW-1:0]    lat_cnt;
    logic             timer_done;
    logic             accept;
    logic             capture;
    logic [WIDTH-1:0] inv_mask;
    logic [WIDTH-1:0] sample;
    logic             unused_readdata;

    assign inv_mask        = (ACTIVE_LOW != 0) ? '1 : '0;
    assign sample          = avm_readdata[WIDTH-1:0] ^ inv_mask;
    assign unused_readdata = ^avm_readdata[31:WIDTH];

    assign avm_address = PIO_DATA_OFFSET;
    assign avm_read    = (state == REQ);
    assign timer_done  = (timer == TW'(POLL_PERIOD - 1));
    assign accept      = avm_read && !avm_waitrequest;
    assign capture     = (state == WAIT_DATA) && (lat_cnt == LW'(READ_LATENCY - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (timer_done) state_next = REQ;
            REQ:       if (accept)     state_next = WAIT_DATA;
            WAIT_DATA: if (capture)    state_next = UPDATE;
            UPDATE:                    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            lat_cnt      <= '0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_next;
            sample_valid <= capture;
            if (state == IDLE && !timer_done) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
            if (state == REQ && accept) begin
                lat_cnt <= '0;
            end else if (state == WAIT_DATA && !capture) begin
                lat_cnt <= lat_cnt + LW'(1);
            end
        end
    end

    // Debounce evaluates on the capture edge so its registered pulses land in UPDATE.
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        debounce_bit #(
            .DEBOUNCE_POLLS(DEBOUNCE_POLLS)
        ) u_debounce (
            .clk          (clk),
            .reset        (reset),
            .sample       (sample[i]),
            .sample_strobe(capture),
            .state        (btn_state[i]),
            .press        (btn_press[i]),
            .released     (btn_release[i])
        );
    end

endmodule

// File: tb/tb_bouttons_avalon_poller.sv
// Scoreboard bench for bouttons_avalon_poller: a behavioural PIO slave queues the
// expected debounce result per poll; a monitor pops and checks on sample_valid.
module tb_bouttons_avalon_poller;

    localparam int WIDTH          = 2;
    localparam int POLL_PERIOD    = 8;
    localparam int DEBOUNCE_POLLS = 4;
    localparam int READ_LATENCY   = 1;
    localparam int ACTIVE_LOW     = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic [1:0]  btn_state;
    logic [1:0]  btn_press;
    logic [1:0]  btn_release;
    logic        sample_valid;

    always #5 clk = ~clk;

    bouttons_avalon_poller #(
        .WIDTH         (WIDTH),
        .POLL_PERIOD   (POLL_PERIOD),
        .DEBOUNCE_POLLS(DEBOUNCE_POLLS),
        .READ_LATENCY  (READ_LATENCY),
        .ACTIVE_LOW    (ACTIVE_LOW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .btn_state      (btn_state),
        .btn_press      (btn_press),
        .btn_release    (btn_release),
        .sample_valid   (sample_valid)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] pr;
        logic [1:0] rl;
    } exp_t;

    exp_t       exp_q[$];
    int         rlen_q[$];
    logic [1:0] raw_q[$];

    int mst[WIDTH];
    int mcnt[WIDTH];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int polls_done = 0;
    int stall_left = 0;
    bit rand_stall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endtask

    // Behavioural PIO slave with the reference debounce model.
    initial begin : slave
        logic       acc;
        int         stalled;
        logic [1:0] p;
        logic [1:0] raw_last;
        logic [31:0] rd;
        exp_t       e;
        stalled  = 0;
        raw_last = 2'b00;
        forever begin
            @(negedge clk);
            acc = !reset && avm_read && !avm_waitrequest;
            if (acc) begin
                rlen_q.push_back(stalled + 1);
                stalled = 0;
            end
            @(posedge clk);
            #1;
            if (reset) begin
                avm_waitrequest = 1'b0;
                avm_readdata    = '0;
                stalled         = 0;
                continue;
            end
            rd = $urandom;
            if (acc) begin
                if (raw_q.size() > 0) p = raw_q.pop_front();
                else                  p = 2'($urandom_range(0, 3));
                rd[1:0]  = (ACTIVE_LOW != 0) ? ~p : p;
                raw_last = rd[1:0];
                e = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (int'(p[i]) != mst[i]) begin
                        mcnt[i] = mcnt[i] + 1;
                        if (mcnt[i] == DEBOUNCE_POLLS) begin
                            mst[i]  = 1 - mst[i];
                            mcnt[i] = 0;
                            if (mst[i] == 1) e.pr[i] = 1'b1;
                            else             e.rl[i] = 1'b1;
                        end
                    end else begin
                        mcnt[i] = 0;
                    end
                    e.st[i] = (mst[i] == 1);
                end
                exp_q.push_back(e);
            end else begin
                // Off-cycle data is the complement, so a mistimed capture is visible.
                rd[1:0] = ~raw_last;
            end
            avm_readdata = rd;
            if (avm_read) begin
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                    stalled++;
                end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                    avm_waitrequest = 1'b1;
                    stalled++;
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : monitor
        int   rd_len;
        int   last_sv;
        logic prev_read;
        exp_t e;
        rd_len    = 0;
        last_sv   = -1;
        prev_read = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                rd_len    = 0;
                last_sv   = -1;
                prev_read = 1'b0;
                continue;
            end
            if (avm_read && !prev_read && last_sv >= 0)
                check("poll_spacing", cyc - last_sv, POLL_PERIOD + 1);
            if (avm_read) begin
                rd_len++;
            end else if (prev_read) begin
                if (rlen_q.size() == 0) check("read_len_unqueued", rd_len, -1);
                else                    check("read_len", rd_len, rlen_q.pop_front());
                rd_len = 0;
            end
            prev_read = avm_read;
            if (sample_valid) begin
                last_sv = cyc;
                polls_done++;
                check("address", int'(avm_address), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("btn_state",   int'(btn_state),   int'(e.st));
                    check("btn_press",   int'(btn_press),   int'(e.pr));
                    check("btn_release", int'(btn_release), int'(e.rl));
                end
            end else begin
                check("idle_pulses", int'({btn_press, btn_release}), 0);
            end
        end
    end

    task automatic measure_first_read();
        int k;
        k = 0;
        while (k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (avm_read) break;
        end
        check("first_read_delay", k, POLL_PERIOD);
    endtask

    task automatic wait_polls(input int n);
        int target;
        int t;
        target = polls_done + n;
        t = 0;
        while (polls_done < target && t < n * 60 + 50) begin
            @(posedge clk);
            t++;
        end
        #2;
        if (polls_done < target) check("poll_timeout", polls_done, target);
    endtask

    task automatic push_raw(input logic [1:0] p, input int n);
        for (int i = 0; i < n; i++) raw_q.push_back(p);
    endtask

    initial begin : watchdog
        #300000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete in time");
        summary();
        $finish;
    end

    initial begin : main
        int t;
        for (int i = 0; i < WIDTH; i++) begin
            mst[i]  = 0;
            mcnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_read",   int'(avm_read),     0);
        check("reset_state",  int'(btn_state),    0);
        check("reset_valid",  int'(sample_valid), 0);
        check("reset_addr",   int'(avm_address),  0);
        reset = 1'b0;
        measure_first_read();

        // Bit 0 held pressed.
        push_raw(2'b01, 4);
        wait_polls(4);

        // Bit 1 bounces once before settling pressed.
        raw_q.push_back(2'b11);
        raw_q.push_back(2'b01);
        push_raw(2'b11, 4);
        wait_polls(6);

        // Both released together, then bit 1 only, then press0 with release1.
        push_raw(2'b00, 4);
        push_raw(2'b10, 4);
        push_raw(2'b01, 4);
        wait_polls(12);

        // Five waitrequest cycles on one request.
        stall_left = 5;
        wait_polls(1);

        rand_stall = 1;
        wait_polls(30);
        rand_stall = 0;

        // Ensure a non-zero debounced state, then reset during a stalled REQ.
        push_raw(2'b11, 4);
        wait_polls(4);
        stall_left = 50;
        t = 0;
        while (!avm_read && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("req_reached", int'(avm_read), 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset_mid_read",  int'(avm_read),  0);
        check("reset_mid_state", int'(btn_state), 0);
        exp_q.delete();
        rlen_q.delete();
        raw_q.delete();
        stall_left = 0;
        for (int i = 0; i < WIDTH; i++) begin
            mst[i]  = 0;
            mcnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        measure_first_read();
        push_raw(2'b10, 5);
        wait_polls(5);

        summary();
        $finish;
    end

endmodule
